// File: rtl/iter_divider_pkg.sv
// Shared encodings for the iterative divider: FSM states and start/ready handshake levels.
package iter_divider_pkg;

   localparam logic DIV_START            = 1'b1;
   localparam logic DIV_STOP             = 1'b0;
   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_DIVZERO = 2'b01,
      ST_RUN     = 2'b10,
      ST_DONE    = 2'b11
   } div_state_e;

endpackage

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider (signed/unsigned), result {rem, quo} pulses ready_o WIDTH+2 cycles after start.
// No backpressure: EX stalls until ready_o; start is only taken in IDLE and not in the ready_o cycle.
module iter_divider
   import iter_divider_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 signed_div_i,
   input  logic [WIDTH-1:0]     opdata1_i,
   input  logic [WIDTH-1:0]     opdata2_i,
   input  logic                 start_i,
   input  logic                 annul_i,
   output logic [2*WIDTH-1:0]   result_o,
   output logic                 ready_o,
   output logic                 busy_o
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   div_state_e           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]     rem_q, rem_d;
   logic [WIDTH-1:0]     quo_q, quo_d;
   logic [WIDTH-1:0]     dvs_q, dvs_d;
   logic                 neg_quo_q, neg_quo_d;
   logic                 neg_rem_q, neg_rem_d;
   logic [2*WIDTH-1:0]   result_q, result_d;
   logic                 ready_q, ready_d;

   logic                 a_neg, b_neg;
   logic [WIDTH-1:0]     abs_a, abs_b;
   logic [WIDTH:0]       trial, diff;
   logic [WIDTH-1:0]     quo_fix, rem_fix;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
         ready_q   <= DIV_RESULT_NOT_READY;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         result_q  <= result_d;
         ready_q   <= ready_d;
      end
   end

   always_comb begin
      a_neg   = signed_div_i & opdata1_i[WIDTH-1];
      b_neg   = signed_div_i & opdata2_i[WIDTH-1];
      abs_a   = a_neg ? -opdata1_i : opdata1_i;
      abs_b   = b_neg ? -opdata2_i : opdata2_i;
      // rem < divisor always, so WIDTH+1 bits hold the shifted remainder and the sign of the trial difference
      trial   = {rem_q, quo_q[WIDTH-1]};
      diff    = trial - {1'b0, dvs_q};
      quo_fix = neg_quo_q ? -quo_q : quo_q;
      rem_fix = neg_rem_q ? -rem_q : rem_q;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;
      ready_d   = DIV_RESULT_NOT_READY;

      case (state_q)
         ST_IDLE: begin
            // ready_q high means DONE just left; a start in that cycle is refused
            if (!annul_i && start_i == DIV_START && !ready_q) begin
               rem_d = '0;
               cnt_d = '0;
               if (opdata2_i == '0) begin
                  quo_d     = opdata1_i;
                  neg_quo_d = 1'b0;
                  neg_rem_d = 1'b0;
                  state_d   = ST_DIVZERO;
               end else begin
                  quo_d     = abs_a;
                  dvs_d     = abs_b;
                  neg_quo_d = a_neg ^ b_neg;
                  neg_rem_d = a_neg;
                  state_d   = ST_RUN;
               end
            end
         end
         ST_DIVZERO: begin
            if (annul_i) begin
               state_d = ST_IDLE;
            end else begin
               rem_d   = quo_q;
               quo_d   = '1;
               state_d = ST_DONE;
            end
         end
         ST_RUN: begin
            if (annul_i) begin
               state_d = ST_IDLE;
            end else begin
               rem_d = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            result_d = {rem_fix, quo_fix};
            ready_d  = DIV_RESULT_READY;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign result_o = result_q;
   assign ready_o  = ready_q;
   assign busy_o   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_iter_divider.sv
// Directed self-checking bench for iter_divider at WIDTH=32.
module tb_iter_divider;

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;
   logic        busy_o;

   int checks = 0;
   int errors = 0;

   iter_divider #(.WIDTH(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o),
      .busy_o       (busy_o)
   );

   always #5 clk = ~clk;

   // Issues one start, scrambles operands afterwards, and watches 40 cycles.
   // lat is the index of the first negedge (1 = right after the start edge) with ready_o high.
   task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] res, output int lat, output int pulses,
                         output int busy_bad);
      res = '0; lat = -1; pulses = 0; busy_bad = 0;
      signed_div_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0; opdata1_i = $urandom; opdata2_i = $urandom;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (ready_o) begin
            if (pulses == 0) begin
               lat = n;
               res = result_o;
            end
            pulses++;
         end else if (pulses == 0 && !busy_o) begin
            busy_bad++;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (result_o !== 64'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", result_o); end
      checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_unsigned;
      logic [63:0] res; int lat, pulses, bb;
      run_op(1'b0, 32'd100, 32'd7, res, lat, pulses, bb);
      checks++; if (res !== {32'd2, 32'd14}) begin errors++; $display("FAIL udiv_100_7: got %h expected %h", res, {32'd2, 32'd14}); end
      checks++; if (lat !== 34) begin errors++; $display("FAIL udiv_latency: got %0d expected 34", lat); end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL udiv_pulses: got %0d expected 1", pulses); end
      checks++; if (bb !== 0) begin errors++; $display("FAIL udiv_busy: got %0d idle cycles expected 0", bb); end
      run_op(1'b0, 32'hFFFFFFF9, 32'd2, res, lat, pulses, bb);
      checks++; if (res !== {32'd1, 32'h7FFFFFFC}) begin errors++; $display("FAIL udiv_big: got %h expected %h", res, {32'd1, 32'h7FFFFFFC}); end
   endtask

   task automatic test_signed;
      logic [63:0] res; int lat, pulses, bb;
      run_op(1'b1, 32'hFFFFFFF9, 32'd2, res, lat, pulses, bb);
      checks++; if (res !== {32'hFFFFFFFF, 32'hFFFFFFFD}) begin errors++; $display("FAIL sdiv_m7_2: got %h expected %h", res, {32'hFFFFFFFF, 32'hFFFFFFFD}); end
      checks++; if (lat !== 34) begin errors++; $display("FAIL sdiv_latency: got %0d expected 34", lat); end
      run_op(1'b1, 32'd7, 32'hFFFFFFFE, res, lat, pulses, bb);
      checks++; if (res !== {32'd1, 32'hFFFFFFFD}) begin errors++; $display("FAIL sdiv_7_m2: got %h expected %h", res, {32'd1, 32'hFFFFFFFD}); end
      run_op(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, res, lat, pulses, bb);
      checks++; if (res !== {32'hFFFFFFFF, 32'd3}) begin errors++; $display("FAIL sdiv_m7_m2: got %h expected %h", res, {32'hFFFFFFFF, 32'd3}); end
   endtask

   task automatic test_divzero;
      logic [63:0] res; int lat, pulses, bb;
      run_op(1'b0, 32'h12345678, 32'd0, res, lat, pulses, bb);
      checks++; if (res !== {32'h12345678, 32'hFFFFFFFF}) begin errors++; $display("FAIL divzero_result: got %h expected %h", res, {32'h12345678, 32'hFFFFFFFF}); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL divzero_latency: got %0d expected 3", lat); end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL divzero_pulses: got %0d expected 1", pulses); end
   endtask

   task automatic test_overflow;
      logic [63:0] res; int lat, pulses, bb;
      run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, res, lat, pulses, bb);
      checks++; if (res !== {32'd0, 32'h80000000}) begin errors++; $display("FAIL overflow_result: got %h expected %h", res, {32'd0, 32'h80000000}); end
      checks++; if (lat !== 34) begin errors++; $display("FAIL overflow_latency: got %0d expected 34", lat); end
   endtask

   task automatic test_annul;
      logic [63:0] res; int lat, pulses, bb;
      run_op(1'b0, 32'd50, 32'd5, res, lat, pulses, bb);
      signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
      @(posedge clk); #1 start_i = 1'b0;
      repeat (10) @(negedge clk);
      annul_i = 1'b1;
      @(posedge clk); #1 annul_i = 1'b0;
      @(negedge clk);
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL annul_busy: got %b expected 0", busy_o); end
      checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL annul_ready: got %b expected 0", ready_o); end
      checks++; if (result_o !== {32'd0, 32'd10}) begin errors++; $display("FAIL annul_result_kept: got %h expected %h", result_o, {32'd0, 32'd10}); end
      run_op(1'b0, 32'd20, 32'd3, res, lat, pulses, bb);
      checks++; if (res !== {32'd2, 32'd6}) begin errors++; $display("FAIL after_annul_result: got %h expected %h", res, {32'd2, 32'd6}); end
      checks++; if (lat !== 34) begin errors++; $display("FAIL after_annul_latency: got %0d expected 34", lat); end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL after_annul_pulses: got %0d expected 1", pulses); end
   endtask

   task automatic test_reset_mid_run;
      int seen = 0;
      signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
      @(posedge clk); #1 start_i = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (result_o !== 64'd0) begin errors++; $display("FAIL midrst_result: got %h expected 0", result_o); end
      checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b expected 0", ready_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy_o); end
      rst = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (ready_o || busy_o) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_quiet: got %0d active cycles expected 0", seen); end
   endtask

   task automatic test_start_with_annul;
      int seen = 0;
      signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
      start_i = 1'b1; annul_i = 1'b1;
      @(posedge clk); #1 start_i = 1'b0; annul_i = 1'b0;
      @(negedge clk);
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL start_annul_busy: got %b expected 0", busy_o); end
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (ready_o) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL start_annul_ready: got %0d pulses expected 0", seen); end
   endtask

   task automatic test_back_to_back;
      int lat1 = -1, lat2 = -1, pulses = 0;
      logic [63:0] res1 = '0, res2 = '0;
      signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
      @(posedge clk); #1;
      opdata1_i = 32'd20; opdata2_i = 32'd3;
      for (int n = 1; n <= 80; n++) begin
         @(negedge clk);
         if (ready_o) begin
            pulses++;
            if (pulses == 1) begin lat1 = n; res1 = result_o; end
            else if (pulses == 2) begin lat2 = n; res2 = result_o; start_i = 1'b0; end
         end
      end
      start_i = 1'b0;
      checks++; if (res1 !== {32'd2, 32'd14}) begin errors++; $display("FAIL b2b_first_result: got %h expected %h", res1, {32'd2, 32'd14}); end
      checks++; if (lat1 !== 34) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 34", lat1); end
      checks++; if (res2 !== {32'd2, 32'd6}) begin errors++; $display("FAIL b2b_second_result: got %h expected %h", res2, {32'd2, 32'd6}); end
      checks++; if (lat2 !== 69) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 69", lat2); end
   endtask

   initial begin
      rst = 1'b1; signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
      start_i = 1'b0; annul_i = 1'b0;
      @(negedge clk);
      test_reset();
      test_unsigned();
      test_signed();
      test_divzero();
      test_overflow();
      test_annul();
      test_reset_mid_run();
      test_start_with_annul();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
